// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button sync/debounce front-end and IDLE/RUN/PAUSE control for the stopwatch core (optional lap/freeze: STOPWATCH_LAP_EN)
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       btn_lap,
    output logic       freeze,
`endif
    output logic       run,
    output logic       clear,
    output logic [1:0] state
);

    localparam int B_START = 0;
    localparam int B_CLEAR = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int B_LAP   = 2;
    localparam int NB      = 3;
`else
    localparam int NB      = 2;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    db;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt [NB];

    state_t cur;
    state_t nxt;
    logic   clr_acc;

`ifdef STOPWATCH_LAP_EN
    assign raw = {btn_lap, btn_clear, btn_start};
`else
    assign raw = {btn_clear, btn_start};
`endif

    // press is raised on the same edge db rises, so the FSM acts one edge later
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            press <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= '0;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]    <= sync2[i];
                    press[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // clear beats start outside RUN; inside RUN only start is honoured
    always_comb begin
        nxt     = cur;
        clr_acc = 1'b0;
        case (cur)
            S_IDLE: begin
                if (press[B_CLEAR])      clr_acc = 1'b1;
                else if (press[B_START]) nxt = S_RUN;
            end
            S_RUN: begin
                if (press[B_START]) nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (press[B_CLEAR]) begin
                    nxt     = S_IDLE;
                    clr_acc = 1'b1;
                end else if (press[B_START]) begin
                    nxt = S_RUN;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur   <= S_IDLE;
            run   <= 1'b0;
            clear <= 1'b0;
        end else begin
            cur   <= nxt;
            run   <= (nxt == S_RUN);
            clear <= clr_acc;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // lap only acts when no start/clear changed the state this cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            freeze <= 1'b0;
        end else if (clr_acc || nxt == S_IDLE) begin
            freeze <= 1'b0;
        end else if (press[B_LAP] && nxt == cur) begin
            freeze <= (cur == S_RUN) ? ~freeze : 1'b0;
        end
    end
`endif

    assign state = cur;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Button front-end placed directly upstream of the stopwatch core. It takes raw, bouncing push-button inputs, synchronises and debounces them, and runs an IDLE/RUN/PAUSE control FSM. It drives two signals into the core: the core's `start` level (the `run` port here) and a one-cycle `clear` pulse that zeroes the count.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clock      input   1  system clock, rising-edge.
reset      input   1  asynchronous, active-high; clears every flop in the block.
btn_start  input   1  raw start/stop button, active-high, asynchronous to clock.
btn_clear  input   1  raw clear button, active-high, asynchronous to clock.
run        output  1  registered level; 1 while the FSM is in RUN; feeds the core's start input.
clear      output  1  registered one-cycle pulse; zeroes the stopwatch count.
state      output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE (11 unused).

Behaviour:
- Reset (async, active-high): all sync flops, debounced levels and counters go to 0; run=0, clear=0, state=00 immediately, with no clock edge required.
- Per button path:
  - 2-flop synchroniser; reset value 0.
  - Debounce: debounced level db changes only after the synced value has differed from db for DEBOUNCE_CYCLES consecutive cycles.
  - The counter returns to 0 on the cycle the synced value equals db, and when db updates; it never wraps.
- Press detect: single-cycle press strobe on db 0->1, in the same cycle db rises. Releases (db 1->0) produce no action.
- Latency: a clean raw high first sampled at edge N sets db at edge N+1+DEBOUNCE_CYCLES; the FSM and outputs update at edge N+2+DEBOUNCE_CYCLES.
- Pulses shorter than DEBOUNCE_CYCLES cycles after synchronisation are ignored.
- FSM transitions (evaluated on each edge using the press strobes):
  - IDLE: start press -> RUN. Clear press -> stay IDLE, clear pulse.
  - RUN: start press -> PAUSE. Clear press ignored.
  - PAUSE: start press -> RUN. Clear press -> IDLE, clear pulse.
  - Illegal 11 -> IDLE.
- Simultaneous start and clear presses in one cycle:
  - In IDLE or PAUSE, clear wins: next state IDLE, clear pulse, start press discarded.
  - In RUN, start wins: next state PAUSE, clear press discarded.
- Outputs:
  - run = registered (next_state==RUN).
  - clear is registered high for exactly one cycle per accepted clear.
  - state is the registered FSM state.
- Reset mid-operation: FSM returns to IDLE. A button still held when reset releases is seen as a fresh press after the full debounce latency, because db restarts at 0.

Optional Feature:
Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input btn_lap (1 bit, raw) and output freeze (1 bit, registered, reset 0).
  - btn_lap uses the same sync/debounce/press path as the other buttons.
  - A lap press in RUN toggles freeze; the core holds its displayed value while freeze=1 and keeps counting.
  - A lap press in PAUSE or IDLE forces freeze=0.
  - Any accepted clear or transition to IDLE forces freeze=0.
  - Lap presses have lowest priority and never change FSM state.
- Undefined: btn_lap and freeze ports and all their logic are absent. The rest of the behaviour is identical.

Test Plan:
(All with DEBOUNCE_CYCLES=4, CNT_W=3.)
1. Assert reset between clock edges with state=RUN -> run=0, clear=0, state=00 before the next edge.
2. btn_start high for 12 cycles from IDLE, first sampled at edge N -> run=1 and state=01 at edge N+6, no earlier. Release -> no change.
3. btn_start high for 3 cycles only -> state stays 00 and run stays 0 for 20 cycles.
4. From RUN: start press -> state=10, run=0. Then clear press -> clear=1 for exactly one cycle, state=00. Clear press in RUN -> no clear pulse, state stays 01.
5. In PAUSE, btn_start and btn_clear rise on the same edge -> state=00, one clear pulse, run stays 0. Same stimulus in RUN -> state=10, no clear pulse.
6. Hold btn_start through a reset pulse; reset releases before edge M -> run=1 at edge M+6. With STOPWATCH_LAP_EN: lap press in RUN -> freeze=1; a second lap press -> freeze=0; lap press then clear from PAUSE -> freeze=0.
